systolic_mm_engine: RTL and testbench

Job-based, parametrised X-by-Y systolic matrix-multiply engine; generalised successor of the plain PE mesh.
- Accepts one A column vector (X elements) and one B row vector (Y elements) per beat over a valid/ready stream.
- Skews operands internally and accumulates K beats per job.
- Presents all X*Y results on an out_valid/out_ready handshake.
- Sits between the operand buffers and the result writer in the matrix-multiplier datapath.

---
 rtl/systolic_pkg.sv | 51 +++++
 rtl/systolic_mm_engine_pe.sv | 112 +++++++++++
 rtl/systolic_mm_engine.sv | 199 +++++++++++++++++++
 tb/tb_systolic_mm_engine.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// Shared types and constant helpers for the systolic matrix-multiply engine.
// Holds the FSM state enum, width helpers and saturation bounds for M-bit accumulators.
package systolic_pkg;

    localparam int DEF_N = 8;
    localparam int DEF_M = 24;
    localparam int DEF_X = 6;
    localparam int DEF_Y = 24;
    localparam int DEF_K = 16;

    // Wide enough to hold any accumulator bound we build
    localparam int SAT_W = 64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    function automatic int clog2(input int v);
        int r;
        int p;
        r = 0;
        p = 1;
        while (p < v) begin
            p = p * 2;
            r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

    // Beat counter must hold 0..K
    function automatic int beat_cnt_w(input int k);
        return clog2(k + 1);
    endfunction

    // Flush counter must hold 0..X+Y-1
    function automatic int flush_cnt_w(input int x, input int y);
        return clog2(x + y);
    endfunction

    function automatic logic signed [SAT_W-1:0] sat_max(input int m);
        return (64'sd1 <<< (m - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [SAT_W-1:0] sat_min(input int m);
        return -(64'sd1 <<< (m - 1));
    endfunction

endpackage

// File: rtl/systolic_mm_engine_pe.sv
// Systolic processing element: registered signed MAC with A/B/valid pass-through.
// Ports: clk, rst (sync, active high), clr (drop accumulator), a_i/b_i + valids in,
// a_o/b_o + valids out (one-cycle registered), acc_o (M-bit accumulator).
// Build option ACC_SAT_EN: accumulator saturates and stays clamped until clr.
module systolic_pe
    import systolic_pkg::*;
#(
    parameter int N = DEF_N,
    parameter int M = DEF_M
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic [N-1:0] a_i,
    input  logic         va_i,
    input  logic [N-1:0] b_i,
    input  logic         vb_i,
    output logic [N-1:0] a_o,
    output logic         va_o,
    output logic [N-1:0] b_o,
    output logic         vb_o,
    output logic [M-1:0] acc_o
);

    logic [N-1:0] a_q, a_d;
    logic [N-1:0] b_q, b_d;
    logic         va_q, va_d;
    logic         vb_q, vb_d;
    logic [M-1:0] acc_q, acc_d;

    logic signed [2*N-1:0] prod;
    logic signed [M-1:0]   prod_ext;
    logic                  mac_en;

    assign prod     = $signed(a_i) * $signed(b_i);
    assign prod_ext = M'(prod);
    assign mac_en   = va_i & vb_i;

`ifdef ACC_SAT_EN
    localparam logic [M-1:0] SMAX = M'(sat_max(M));
    localparam logic [M-1:0] SMIN = M'(sat_min(M));

    logic         sat_q, sat_d;
    logic [M:0]   sum;

    // One extra bit exposes signed overflow: top two bits disagree
    assign sum = {acc_q[M-1], acc_q} + {prod_ext[M-1], prod_ext};

    always_comb begin
        acc_d = acc_q;
        sat_d = sat_q;
        if (clr) begin
            acc_d = '0;
            sat_d = 1'b0;
        end else if (mac_en && !sat_q) begin
            if (sum[M] != sum[M-1]) begin
                acc_d = sum[M] ? SMIN : SMAX;
                sat_d = 1'b1;
            end else begin
                acc_d = sum[M-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sat_q <= 1'b0;
        end else begin
            sat_q <= sat_d;
        end
    end
`else
    always_comb begin
        acc_d = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (mac_en) begin
            acc_d = acc_q + prod_ext;
        end
    end
`endif

    always_comb begin
        a_d  = a_i;
        b_d  = b_i;
        va_d = va_i;
        vb_d = vb_i;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q   <= '0;
            b_q   <= '0;
            va_q  <= 1'b0;
            vb_q  <= 1'b0;
            acc_q <= '0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            va_q  <= va_d;
            vb_q  <= vb_d;
            acc_q <= acc_d;
        end
    end

    assign a_o   = a_q;
    assign b_o   = b_q;
    assign va_o  = va_q;
    assign vb_o  = vb_q;
    assign acc_o = acc_q;

endmodule

// File: rtl/systolic_mm_engine.sv
// Job-based X-by-Y systolic matrix-multiply engine: K A/B beats in, X*Y results out.
// Ports: clk, rst (sync, active high); in_valid/in_ready with a_in (X*N), b_in (Y*N);
// out_valid/out_ready with d_out (X*Y*M, C[i][j] at (i*Y+j)*M); busy in LOAD/FLUSH.
// Build option ACC_SAT_EN selects saturating accumulators inside the PEs.
module systolic_mm_engine
    import systolic_pkg::*;
#(
    parameter int N = DEF_N,
    parameter int M = DEF_M,
    parameter int X = DEF_X,
    parameter int Y = DEF_Y,
    parameter int K = DEF_K
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [X*N-1:0]   a_in,
    input  logic [Y*N-1:0]   b_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [X*Y*M-1:0] d_out,
    output logic             busy
);

    localparam int BEAT_W  = beat_cnt_w(K);
    localparam int FLUSH_W = flush_cnt_w(X, Y);

    state_e             state_q, state_d;
    logic [BEAT_W-1:0]  bcnt_q, bcnt_d;
    logic [FLUSH_W-1:0] fcnt_q, fcnt_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic               busy_q, busy_d;

    logic beat;
    logic hs;

    assign beat = in_valid & in_ready_q;
    assign hs   = out_valid_q & out_ready;

    always_comb begin
        state_d = state_q;
        bcnt_d  = bcnt_q;
        fcnt_d  = fcnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (beat) begin
                    bcnt_d = BEAT_W'(1);
                    fcnt_d = '0;
                    state_d = (K == 1) ? ST_FLUSH : ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (beat) begin
                    bcnt_d = bcnt_q + BEAT_W'(1);
                    if (bcnt_q == BEAT_W'(K - 1)) begin
                        state_d = ST_FLUSH;
                        fcnt_d  = '0;
                    end
                end
            end
            ST_FLUSH: begin
                // Last PE accumulates X+Y-1 edges after the final beat
                if (fcnt_q == FLUSH_W'(X + Y - 1)) begin
                    state_d = ST_DONE;
                end else begin
                    fcnt_d = fcnt_q + FLUSH_W'(1);
                end
            end
            ST_DONE: begin
                if (hs) begin
                    state_d = ST_IDLE;
                    bcnt_d  = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        in_ready_d  = (state_d == ST_IDLE) || (state_d == ST_LOAD);
        out_valid_d = (state_d == ST_DONE);
        busy_d      = (state_d == ST_LOAD) || (state_d == ST_FLUSH);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            bcnt_q      <= '0;
            fcnt_q      <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            bcnt_q      <= bcnt_d;
            fcnt_q      <= fcnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;

    // Mesh interconnect; column Y / row X entries are the unused far edges
    logic [N-1:0] ah  [X][Y+1];
    logic         avh [X][Y+1];
    logic [N-1:0] bv  [X+1][Y];
    logic         bvv [X+1][Y];
    logic [M-1:0] acc [X][Y];

    // Row i of A enters the mesh i cycles later than row 0
    for (genvar i = 0; i < X; i++) begin : g_askew
        logic [i:0][N-1:0] sk_q, sk_d;
        logic [i:0]        sv_q, sv_d;

        always_comb begin
            sk_d[0] = a_in[i*N +: N];
            sv_d[0] = beat;
            for (int s = 1; s <= i; s++) begin
                sk_d[s] = sk_q[s-1];
                sv_d[s] = sv_q[s-1];
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                sk_q <= '0;
                sv_q <= '0;
            end else begin
                sk_q <= sk_d;
                sv_q <= sv_d;
            end
        end

        assign ah[i][0]  = sk_q[i];
        assign avh[i][0] = sv_q[i];

        logic unused_a_edge;
        assign unused_a_edge = ^{ah[i][Y], avh[i][Y]};
    end

    // Column j of B enters the mesh j cycles later than column 0
    for (genvar j = 0; j < Y; j++) begin : g_bskew
        logic [j:0][N-1:0] sk_q, sk_d;
        logic [j:0]        sv_q, sv_d;

        always_comb begin
            sk_d[0] = b_in[j*N +: N];
            sv_d[0] = beat;
            for (int s = 1; s <= j; s++) begin
                sk_d[s] = sk_q[s-1];
                sv_d[s] = sv_q[s-1];
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                sk_q <= '0;
                sv_q <= '0;
            end else begin
                sk_q <= sk_d;
                sv_q <= sv_d;
            end
        end

        assign bv[0][j]  = sk_q[j];
        assign bvv[0][j] = sv_q[j];

        logic unused_b_edge;
        assign unused_b_edge = ^{bv[X][j], bvv[X][j]};
    end

    for (genvar i = 0; i < X; i++) begin : g_row
        for (genvar j = 0; j < Y; j++) begin : g_col
            systolic_pe #(
                .N(N),
                .M(M)
            ) u_pe (
                .clk  (clk),
                .rst  (rst),
                .clr  (hs),
                .a_i  (ah[i][j]),
                .va_i (avh[i][j]),
                .b_i  (bv[i][j]),
                .vb_i (bvv[i][j]),
                .a_o  (ah[i][j+1]),
                .va_o (avh[i][j+1]),
                .b_o  (bv[i+1][j]),
                .vb_o (bvv[i+1][j]),
                .acc_o(acc[i][j])
            );

            assign d_out[(i*Y+j)*M +: M] = acc[i][j];
        end
    end

endmodule

// File: tb/tb_systolic_mm_engine.sv
// Scoreboard bench for systolic_mm_engine: driver pushes model results, monitor pops.
// Expected results come from a plain sum-of-products model over each job's beats.
module tb_systolic_mm_engine;

    localparam int N = 8;
    localparam int M = 16;
    localparam int X = 2;
    localparam int Y = 3;
    localparam int K = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [X*N-1:0]   a_in;
    logic [Y*N-1:0]   b_in;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [X*Y*M-1:0] d_out;
    logic             busy;

    systolic_mm_engine #(
        .N(N), .M(M), .X(X), .Y(Y), .K(K)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a_in     (a_in),
        .b_in     (b_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .d_out    (d_out),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [X*Y*M-1:0] d;
        int               lat;
        int               stall;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   hs_edge = -10;

    int ja [K][X];
    int jb [K][Y];

    // Reference: C[i][j] = sum over beats of A_k[i]*B_k[j], wrapped or clamped to M bits
    function automatic logic [X*Y*M-1:0] model();
        logic [X*Y*M-1:0] r;
        r = '0;
        for (int i = 0; i < X; i++) begin
            for (int j = 0; j < Y; j++) begin
                longint acc;
                acc = 0;
`ifdef ACC_SAT_EN
                begin
                    longint mx;
                    longint mn;
                    bit     sat;
                    mx  = (longint'(1) <<< (M - 1)) - 1;
                    mn  = -mx - 1;
                    sat = 1'b0;
                    for (int k = 0; k < K; k++) begin
                        if (!sat) begin
                            acc = acc + longint'(ja[k][i]) * longint'(jb[k][j]);
                            if (acc > mx) begin
                                acc = mx;
                                sat = 1'b1;
                            end else if (acc < mn) begin
                                acc = mn;
                                sat = 1'b1;
                            end
                        end
                    end
                end
`else
                for (int k = 0; k < K; k++) begin
                    acc = acc + longint'(ja[k][i]) * longint'(jb[k][j]);
                end
`endif
                r[(i*Y+j)*M +: M] = acc[M-1:0];
            end
        end
        return r;
    endfunction

    task automatic run_job(input int gap, input int stall, input bit expect_out,
                           input bit hold, input bit b2b);
        logic [X*Y*M-1:0] e;
        int n;
        int t0;
        e = model();
        t0 = 0;
        for (int k = 0; k < K; k++) begin
            if (k > 0) begin
                for (int g = 0; g < gap; g++) begin
                    @(negedge clk);
                    in_valid = 1'b0;
                end
            end
            @(negedge clk);
            in_valid = 1'b1;
            for (int i = 0; i < X; i++) a_in[i*N +: N] = ja[k][i][N-1:0];
            for (int j = 0; j < Y; j++) b_in[j*N +: N] = jb[k][j][N-1:0];
            n = 0;
            while (!in_ready && n < 200) begin
                @(negedge clk);
                n++;
            end
            if (n >= 200) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout beat=%0d waited=%0d limit=200", k, n);
            end
            t0 = cyc + 1;
            if (k == 0 && b2b) begin
                checks++;
                if (t0 != hs_edge + 1) begin
                    errors++;
                    $display("FAIL b2b_accept edge=%0d required=%0d", t0, hs_edge + 1);
                end
            end
        end
        if (expect_out) q.push_back('{d: e, lat: t0 + X + Y, stall: stall});
        if (!hold) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    // Monitor: pops on rising out_valid, checks latency, data and stall stability
    bit               prev_v = 1'b0;
    int               remaining = 0;
    logic [X*Y*M-1:0] snap = '0;

    always @(negedge clk) begin
        if (rst) begin
            prev_v    = 1'b0;
            remaining = 0;
            out_ready = 1'b0;
        end else if (out_valid) begin
            if (!prev_v) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out_valid edge=%0d d_out=%h", cyc, d_out);
                    remaining = 0;
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    checks++;
                    if (cyc != e.lat) begin
                        errors++;
                        $display("FAIL latency rise_edge=%0d required=%0d", cyc, e.lat);
                    end
                    checks++;
                    if (d_out !== e.d) begin
                        errors++;
                        $display("FAIL result d_out=%h required=%h", d_out, e.d);
                    end
                    remaining = e.stall;
                end
                snap = d_out;
            end else begin
                checks++;
                if (d_out !== snap) begin
                    errors++;
                    $display("FAIL stall_stable d_out=%h required=%h", d_out, snap);
                end
            end
            prev_v = 1'b1;
            if (remaining > 0) begin
                out_ready = 1'b0;
                remaining--;
            end else begin
                out_ready = 1'b1;
                hs_edge   = cyc + 1;
                prev_v    = 1'b0;
            end
        end else begin
            prev_v    = 1'b0;
            out_ready = 1'($urandom_range(1));
        end
    end

    task automatic chk(input string name, input logic [X*Y*M-1:0] act,
                       input logic [X*Y*M-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic set_ex1(input int b2c0, input int b2c1);
        ja[0][0] = 1;  ja[0][1] = 2;
        ja[1][0] = 3;  ja[1][1] = 4;
        jb[0][0] = 5;  jb[0][1] = 6;  jb[0][2] = b2c0;
        jb[1][0] = 7;  jb[1][1] = 8;  jb[1][2] = b2c1;
    endtask

    task automatic set_all(input int av, input int bv);
        for (int k = 0; k < K; k++) begin
            for (int i = 0; i < X; i++) ja[k][i] = av;
            for (int j = 0; j < Y; j++) jb[k][j] = bv;
        end
    endtask

    task automatic set_rand();
        for (int k = 0; k < K; k++) begin
            for (int i = 0; i < X; i++) ja[k][i] = int'($urandom_range(255)) - 128;
            for (int j = 0; j < Y; j++) jb[k][j] = int'($urandom_range(255)) - 128;
        end
    endtask

    initial begin
        int  n;
        bit  prev_hold;
        bit  hold;
        rst      = 1'b1;
        in_valid = 1'b0;
        a_in     = '0;
        b_in     = '0;
        repeat (3) @(negedge clk);
        chk("reset_in_ready", 96'(in_ready), 96'(0));
        chk("reset_out_valid", 96'(out_valid), 96'(0));
        chk("reset_busy", 96'(busy), 96'(0));
        chk("reset_d_out", d_out, '0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_in_ready", 96'(in_ready), 96'(1));
        chk("idle_out_valid", 96'(out_valid), 96'(0));
        chk("idle_busy", 96'(busy), 96'(0));
        chk("idle_d_out", d_out, '0);

        // Reference job, back-to-back beats, result held off for 5 cycles
        set_ex1(1, 2);
        run_job(0, 5, 1'b1, 1'b0, 1'b0);
        repeat (16) @(negedge clk);

        // Same job with a 3-cycle bubble between beats
        run_job(3, 0, 1'b1, 1'b0, 1'b0);
        repeat (16) @(negedge clk);

        // Most-negative operands overflow the 16-bit accumulator
        set_all(-128, -128);
        run_job(0, 1, 1'b1, 1'b0, 1'b0);
        repeat (16) @(negedge clk);

        // Reset while the job is flushing: nothing may be presented
        set_ex1(-7, 9);
        run_job(0, 0, 1'b0, 1'b0, 1'b0);
        chk("flush_busy", 96'(busy), 96'(1));
        chk("flush_in_ready", 96'(in_ready), 96'(0));
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_in_ready", 96'(in_ready), 96'(0));
        chk("midrst_out_valid", 96'(out_valid), 96'(0));
        chk("midrst_busy", 96'(busy), 96'(0));
        chk("midrst_d_out", d_out, '0);
        rst = 1'b0;
        repeat (X + Y + 6) @(negedge clk);

        // Unit operands: every C equals K, proving no residue survived
        set_all(1, 1);
        run_job(0, 0, 1'b1, 1'b0, 1'b0);
        repeat (16) @(negedge clk);

        // Two jobs with in_valid held high through FLUSH/DONE
        set_ex1(-3, 11);
        run_job(0, 2, 1'b1, 1'b1, 1'b0);
        set_rand();
        run_job(0, 0, 1'b1, 1'b0, 1'b1);
        repeat (16) @(negedge clk);

        // Randomised jobs: random data, bubbles, back-pressure and chaining
        prev_hold = 1'b0;
        for (int t = 0; t < 24; t++) begin
            set_rand();
            hold = 1'($urandom_range(1));
            run_job(int'($urandom_range(2)), int'($urandom_range(3)), 1'b1, hold, prev_hold);
            prev_hold = hold;
        end
        @(negedge clk);
        in_valid = 1'b0;

        n = 0;
        while (q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout pending=%0d required=0", q.size());
        end
        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
